decode_stage: RTL and testbench

Registered, parametrised RISC-V decode pipeline stage. It takes fetched instructions over a valid/ready handshake and presents fully decoded fields (format, register indices, function codes, sign-extended immediate, illegal flag) to execute one cycle later. A two-entry skid buffer sustains one instruction per cycle under back-pressure. It supports RV32I and RV64I base opcodes, selected by parameter, and replaces the purely combinational decoder in the front end.

---
 rtl/decode_stage_pkg.sv | 52 +++++
 rtl/decode_stage_field_decode.sv | 68 ++++++
 rtl/decode_stage.sv | 122 ++++++++++++
 tb/tb_decode_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RISC-V decode types: instruction formats, base opcodes and the decoded-instruction payload.
package decode_stage_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;

  // INVALID_TYPE is the all-zero encoding so a cleared entry reads as "nothing decoded".
  typedef enum logic [2:0] {
    INVALID_TYPE = 3'd0,
    R_TYPE       = 3'd1,
    I_TYPE       = 3'd2,
    S_TYPE       = 3'd3,
    B_TYPE       = 3'd4,
    U_TYPE       = 3'd5,
    J_TYPE       = 3'd6
  } inst_format_e;

  localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_FENCE     = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;

  // imm holds the 32-bit sign-extended value; widening to XLEN is a pure sign extension.
  typedef struct packed {
    inst_format_e      format;
    logic [OPC_W-1:0]  opcode;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [INST_W-1:0] imm;
    logic              illegal;
  } decoded_inst_t;

  function automatic logic is_shift_funct3(input logic [F3_W-1:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/decode_stage_field_decode.sv
// Combinational field decoder: raw instruction to decoded_inst_t for RV32I/RV64I base opcodes.
module inst_field_decode
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] inst_i,
  output decoded_inst_t     dec_o
);

  logic [OPC_W-1:0]  opc;
  inst_format_e      fmt;
  logic [INST_W-1:0] imm;
  logic [F7_W-1:0]   f7;

  assign opc = inst_i[6:0];

  always_comb begin
    fmt = INVALID_TYPE;
    unique case (opc)
      OPC_OP:                                         fmt = R_TYPE;
      OPC_OP_32:                                      if (XLEN == 64) fmt = R_TYPE;
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM: fmt = I_TYPE;
      OPC_OP_IMM_32:                                  if (XLEN == 64) fmt = I_TYPE;
      OPC_STORE:                                      fmt = S_TYPE;
      OPC_BRANCH:                                     fmt = B_TYPE;
      OPC_AUIPC, OPC_LUI:                             fmt = U_TYPE;
      OPC_JAL:                                        fmt = J_TYPE;
      default:                                        fmt = INVALID_TYPE;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (fmt)
      I_TYPE: imm = {{20{inst_i[31]}}, inst_i[31:20]};
      S_TYPE: imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      B_TYPE: imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      U_TYPE: imm = {inst_i[31:12], 12'b0};
      J_TYPE: imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // RV64 OP-IMM shifts use a 6-bit shamt, so bit 25 belongs to the shift amount, not funct7.
  always_comb begin
    f7 = '0;
    if (fmt == R_TYPE) begin
      f7 = inst_i[31:25];
    end else if (is_shift_funct3(inst_i[14:12]) && (opc == OPC_OP_IMM || opc == OPC_OP_IMM_32)) begin
      f7 = (opc == OPC_OP_IMM && XLEN == 64) ? {inst_i[31:26], 1'b0} : inst_i[31:25];
    end
  end

  always_comb begin
    dec_o         = '0;
    dec_o.format  = fmt;
    dec_o.opcode  = opc;
    dec_o.funct3  = inst_i[14:12];
    dec_o.funct7  = f7;
    dec_o.rs1     = inst_i[19:15];
    dec_o.rs2     = inst_i[24:20];
    dec_o.rd      = inst_i[11:7];
    dec_o.imm     = imm;
    dec_o.illegal = (fmt == INVALID_TYPE) || (inst_i[1:0] != 2'b11);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready input, one-cycle latency, optional two-entry skid buffer.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          SKID = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output inst_format_e      format_o,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [F3_W-1:0]   funct3_o,
  output logic [F7_W-1:0]   funct7_o,
  output logic [REG_W-1:0]  rs1_o,
  output logic [REG_W-1:0]  rs2_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [XLEN-1:0]   imm_o,
  output logic              illegal_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]      state_q, state_d;
  decoded_inst_t   dec_c;
  decoded_inst_t   out_q, out_d, skid_q, skid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
  logic            ready_q, ready_d;
  logic            accept_c, drain_c;

  inst_field_decode #(.XLEN(XLEN)) u_field_decode (
    .inst_i (inst_i),
    .dec_o  (dec_c)
  );

  assign accept_c = in_valid_i && ready_q;
  assign drain_c  = (state_q != ST_EMPTY) && out_ready_i;

  // With SKID=0 ready drops whenever the output is occupied, so ST_ONE never sees an accept.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    out_pc_d  = out_pc_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d  = ST_ONE;
            out_d    = dec_c;
            out_pc_d = pc_i;
          end
        end
        ST_ONE: begin
          if (accept_c && drain_c) begin
            out_d    = dec_c;
            out_pc_d = pc_i;
          end else if (accept_c) begin
            state_d   = ST_FULL;
            skid_d    = dec_c;
            skid_pc_d = pc_i;
          end else if (drain_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain_c) begin
            state_d  = ST_ONE;
            out_d    = skid_q;
            out_pc_d = skid_pc_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    ready_d = SKID ? (state_d != ST_FULL) : (state_d == ST_EMPTY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_EMPTY;
      out_q     <= '0;
      out_pc_q  <= '0;
      skid_q    <= '0;
      skid_pc_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      out_pc_q  <= out_pc_d;
      skid_q    <= skid_d;
      skid_pc_q <= skid_pc_d;
      ready_q   <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = state_q != ST_EMPTY;
  assign pc_o        = out_pc_q;
  assign format_o    = out_q.format;
  assign opcode_o    = out_q.opcode;
  assign funct3_o    = out_q.funct3;
  assign funct7_o    = out_q.funct7;
  assign rs1_o       = out_q.rs1;
  assign rs2_o       = out_q.rs2;
  assign rd_o        = out_q.rd;
  assign imm_o       = XLEN'($signed(out_q.imm));
  assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: RV32 skid, RV64 skid and RV32 single-register instances share stimulus.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] inst;
  logic [31:0] pc32;
  logic [63:0] pc64;

  logic a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_pc, a_imm;
  inst_format_e a_fmt;
  logic [6:0] a_opc, a_f7;
  logic [2:0] a_f3;
  logic [4:0] a_rs1, a_rs2, a_rd;

  logic b_in_ready, b_out_valid, b_ill;
  logic [63:0] b_pc, b_imm;
  inst_format_e b_fmt;
  logic [6:0] b_opc, b_f7;
  logic [2:0] b_f3;
  logic [4:0] b_rs1, b_rs2, b_rd;

  logic c_in_ready, c_out_valid, c_ill;
  logic [31:0] c_pc, c_imm;
  inst_format_e c_fmt;
  logic [6:0] c_opc, c_f7;
  logic [2:0] c_f3;
  logic [4:0] c_rs1, c_rs2, c_rd;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID(1'b1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .inst_i(inst), .pc_i(pc32), .out_valid_o(a_out_valid), .out_ready_i(out_ready), .pc_o(a_pc),
    .format_o(a_fmt), .opcode_o(a_opc), .funct3_o(a_f3), .funct7_o(a_f7), .rs1_o(a_rs1),
    .rs2_o(a_rs2), .rd_o(a_rd), .imm_o(a_imm), .illegal_o(a_ill));

  decode_stage #(.XLEN(64), .SKID(1'b1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .inst_i(inst), .pc_i(pc64), .out_valid_o(b_out_valid), .out_ready_i(out_ready), .pc_o(b_pc),
    .format_o(b_fmt), .opcode_o(b_opc), .funct3_o(b_f3), .funct7_o(b_f7), .rs1_o(b_rs1),
    .rs2_o(b_rs2), .rd_o(b_rd), .imm_o(b_imm), .illegal_o(b_ill));

  decode_stage #(.XLEN(32), .SKID(1'b0)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(c_in_ready),
    .inst_i(inst), .pc_i(pc32), .out_valid_o(c_out_valid), .out_ready_i(out_ready), .pc_o(c_pc),
    .format_o(c_fmt), .opcode_o(c_opc), .funct3_o(c_f3), .funct7_o(c_f7), .rs1_o(c_rs1),
    .rs2_o(c_rs2), .rd_o(c_rd), .imm_o(c_imm), .illegal_o(c_ill));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input inst_format_e fmt, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                         input logic ill);
    check_val({tag, "/a.valid"}, 64'(a_out_valid), 64'(1'b1));
    check_val({tag, "/a.fmt"},   64'(a_fmt),       64'(fmt));
    check_val({tag, "/a.rd"},    64'(a_rd),        64'(rd));
    check_val({tag, "/a.rs1"},   64'(a_rs1),       64'(rs1));
    check_val({tag, "/a.rs2"},   64'(a_rs2),       64'(rs2));
    check_val({tag, "/a.imm"},   64'(a_imm),       64'(imm));
    check_val({tag, "/a.ill"},   64'(a_ill),       64'(ill));
  endtask

  task automatic check_b(input string tag, input inst_format_e fmt, input logic [63:0] imm,
                         input logic ill);
    check_val({tag, "/b.valid"}, 64'(b_out_valid), 64'(1'b1));
    check_val({tag, "/b.fmt"},   64'(b_fmt),       64'(fmt));
    check_val({tag, "/b.imm"},   b_imm,            imm);
    check_val({tag, "/b.ill"},   64'(b_ill),       64'(ill));
  endtask

  // One accepted instruction with out_ready high; returns on the negedge after the accepting edge.
  task automatic issue(input logic [31:0] i, input logic [63:0] pc);
    inst     = i;
    pc32     = pc[31:0];
    pc64     = pc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst = '0; pc32 = '0; pc64 = '0;
    repeat (2) @(negedge clk);

    check_val("rst/a.valid", 64'(a_out_valid), 64'(1'b0));
    check_val("rst/a.ready", 64'(a_in_ready),  64'(1'b0));
    check_val("rst/a.fmt",   64'(a_fmt),       64'(INVALID_TYPE));
    check_val("rst/a.imm",   64'(a_imm),       64'(0));
    check_val("rst/a.ill",   64'(a_ill),       64'(0));
    check_val("rst/b.ready", 64'(b_in_ready),  64'(1'b0));
    check_val("rst/c.ready", 64'(c_in_ready),  64'(1'b0));

    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("post_rst/a.ready", 64'(a_in_ready),  64'(1'b1));
    check_val("post_rst/a.valid", 64'(a_out_valid), 64'(1'b0));
    check_val("post_rst/a.pc",    64'(a_pc),        64'(0));

    issue(32'hFFF00093, 64'h100);
    check_a("addi", I_TYPE, 5'd1, 5'd0, 5'd31, 32'hFFFF_FFFF, 1'b0);
    check_b("addi", I_TYPE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check_val("addi/a.pc", 64'(a_pc), 64'h100);
    check_val("addi/b.pc", b_pc,      64'h100);
    check_val("addi/a.f7", 64'(a_f7), 64'(0));

    issue(32'hFE000EE3, 64'h104);
    check_a("beq", B_TYPE, 5'd29, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
    check_b("beq", B_TYPE, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);

    issue(32'h0020A423, 64'h108);
    check_a("sw", S_TYPE, 5'd8, 5'd1, 5'd2, 32'h8, 1'b0);
    check_val("sw/a.f7",  64'(a_f7),  64'(0));
    check_val("sw/a.f3",  64'(a_f3),  64'(3'b010));
    check_val("sw/a.opc", 64'(a_opc), 64'(7'h23));

    issue(32'h4010D09B, 64'h10C);
    check_a("sraiw", INVALID_TYPE, 5'd1, 5'd1, 5'd1, 32'h0, 1'b1);
    check_b("sraiw", I_TYPE, 64'h401, 1'b0);
    check_val("sraiw/b.f7", 64'(b_f7), 64'h20);

    issue(32'h4210D093, 64'h110);
    check_a("srai", I_TYPE, 5'd1, 5'd1, 5'd1, 32'h421, 1'b0);
    check_val("srai/a.f7", 64'(a_f7), 64'h21);
    check_val("srai/b.f7", 64'(b_f7), 64'h20);

    issue(32'h0000_0000, 64'h114);
    check_a("zero", INVALID_TYPE, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);

    issue(32'h800000B7, 64'h118);
    check_a("lui", U_TYPE, 5'd1, 5'd0, 5'd0, 32'h8000_0000, 1'b0);
    check_b("lui", U_TYPE, 64'hFFFF_FFFF_8000_0000, 1'b0);

    issue(32'hFFDFF0EF, 64'h11C);
    check_a("jal", J_TYPE, 5'd1, 5'd31, 5'd29, 32'hFFFF_FFFC, 1'b0);
    check_b("jal", J_TYPE, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);

    issue(32'h40208033, 64'h120);
    check_a("sub", R_TYPE, 5'd0, 5'd1, 5'd2, 32'h0, 1'b0);
    check_val("sub/a.f7", 64'(a_f7), 64'h20);

    issue(32'h4020803B, 64'h124);
    check_a("subw", INVALID_TYPE, 5'd0, 5'd1, 5'd2, 32'h0, 1'b1);
    check_val("subw/a.f7", 64'(a_f7), 64'(0));
    check_b("subw", R_TYPE, 64'h0, 1'b0);
    check_val("subw/b.f7", 64'(b_f7), 64'h20);

    // Back-pressure: instructions are addi x1,x0,k so imm identifies each one.
    idle(2);
    out_ready = 1'b0;
    inst = 32'h00100093; in_valid = 1'b1;
    @(negedge clk);
    check_a("bp0", I_TYPE, 5'd1, 5'd0, 5'd1, 32'd1, 1'b0);
    check_val("bp0/a.ready", 64'(a_in_ready), 64'(1'b1));
    check_val("bp0/c.ready", 64'(c_in_ready), 64'(1'b0));
    inst = 32'h00200093;
    @(negedge clk);
    check_val("bp1/a.ready", 64'(a_in_ready), 64'(1'b0));
    check_val("bp1/a.imm",   64'(a_imm),      64'd1);
    inst = 32'h00300093;
    @(negedge clk);
    check_val("bp2/a.ready", 64'(a_in_ready), 64'(1'b0));
    check_val("bp2/a.imm",   64'(a_imm),      64'd1);
    check_val("bp2/c.imm",   64'(c_imm),      64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check_val("bp3/a.valid", 64'(a_out_valid), 64'(1'b1));
    check_val("bp3/a.imm",   64'(a_imm),       64'd2);
    check_val("bp3/a.ready", 64'(a_in_ready),  64'(1'b1));
    check_val("bp3/c.valid", 64'(c_out_valid), 64'(1'b0));
    @(negedge clk);
    check_val("bp4/a.valid", 64'(a_out_valid), 64'(1'b1));
    check_val("bp4/a.imm",   64'(a_imm),       64'd3);
    check_val("bp4/c.valid", 64'(c_out_valid), 64'(1'b1));
    check_val("bp4/c.imm",   64'(c_imm),       64'd3);
    inst = 32'h00400093;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("bp5/a.valid", 64'(a_out_valid), 64'(1'b1));
    check_val("bp5/a.imm",   64'(a_imm),       64'd4);
    @(negedge clk);
    check_val("bp6/a.valid", 64'(a_out_valid), 64'(1'b0));

    // Flush while FULL with an instruction offered.
    idle(2);
    out_ready = 1'b0;
    inst = 32'h00100093; in_valid = 1'b1;
    @(negedge clk);
    inst = 32'h00200093;
    @(negedge clk);
    check_val("fl_full/a.ready", 64'(a_in_ready), 64'(1'b0));
    flush = 1'b1; inst = 32'h00300093;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check_val("fl_full/a.valid", 64'(a_out_valid), 64'(1'b0));
    check_val("fl_full/a.ready", 64'(a_in_ready),  64'(1'b1));
    out_ready = 1'b1;
    @(negedge clk);
    check_val("fl_full/a.valid2", 64'(a_out_valid), 64'(1'b0));

    // Flush in ONE while ready is high: the offered instruction must be dropped.
    issue(32'h00100093, 64'h200);
    check_val("fl_one/a.valid0", 64'(a_out_valid), 64'(1'b1));
    flush = 1'b1; inst = 32'h00400093; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check_val("fl_one/a.valid", 64'(a_out_valid), 64'(1'b0));
    check_val("fl_one/a.ready", 64'(a_in_ready),  64'(1'b1));
    @(negedge clk);
    check_val("fl_one/a.valid2", 64'(a_out_valid), 64'(1'b0));

    // Reset with the buffer FULL.
    idle(2);
    out_ready = 1'b0;
    inst = 32'h00100093; pc32 = 32'h300; in_valid = 1'b1;
    @(negedge clk);
    inst = 32'h00200093;
    @(negedge clk);
    check_val("mrst/a.full", 64'(a_in_ready), 64'(1'b0));
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_val("mrst/a.valid", 64'(a_out_valid), 64'(1'b0));
    check_val("mrst/a.ready", 64'(a_in_ready),  64'(1'b0));
    check_val("mrst/a.imm",   64'(a_imm),       64'(0));
    check_val("mrst/a.fmt",   64'(a_fmt),       64'(INVALID_TYPE));
    check_val("mrst/a.pc",    64'(a_pc),        64'(0));
    check_val("mrst/a.rd",    64'(a_rd),        64'(0));
    rst = 1'b0;
    @(negedge clk);
    check_val("mrst/a.ready1", 64'(a_in_ready),  64'(1'b1));
    check_val("mrst/a.valid1", 64'(a_out_valid), 64'(1'b0));
    out_ready = 1'b1;
    issue(32'h00400093, 64'h400);
    check_a("mrst_resume", I_TYPE, 5'd1, 5'd0, 5'd4, 32'd4, 1'b0);
    check_val("mrst_resume/a.pc", 64'(a_pc), 64'h400);

    idle(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
